// File: rtl/control_unit.sv
// rtl/control_unit.sv - single-cycle instruction decode with active/halted gating
// Optional halt latch enabled by defining CONTROL_HALT_LATCH_EN.
module control_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] opcode,
   input  logic [3:0] funct_code,
   input  logic [2:0] hazard,
   output logic [1:0] byte_access,
   output logic [2:0] alu_op,
   output logic [1:0] alu_src,
   output logic [1:0] write_back,
   output logic       mem_write,
   output logic       mem_read,
   output logic       write_enable_1,
   output logic       write_enable_2,
   output logic       write_data_2,
   output logic       if_flush,
   output logic       pc_src
);

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ANDI  = 4'b0001;
   localparam logic [3:0] OP_ORI   = 4'b0010;
   localparam logic [3:0] OP_BLT   = 4'b0100;
   localparam logic [3:0] OP_BGT   = 4'b0101;
   localparam logic [3:0] OP_BEQ   = 4'b0110;
   localparam logic [3:0] OP_LB    = 4'b1000;
   localparam logic [3:0] OP_SB    = 4'b1001;
   localparam logic [3:0] OP_LW    = 4'b1010;
   localparam logic [3:0] OP_SW    = 4'b1011;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   localparam logic [3:0] FN_ADD  = 4'b0000;
   localparam logic [3:0] FN_SUB  = 4'b0001;
   localparam logic [3:0] FN_MULT = 4'b0100;
   localparam logic [3:0] FN_DIV  = 4'b1000;
   localparam logic [3:0] FN_MOVE = 4'b1110;
   localparam logic [3:0] FN_SWAP = 4'b1111;

   logic active_q, active_d;
   logic halted_q;
   logic decode_en;

   // A load-use stall turns the whole instruction into a bubble.
   assign decode_en = active_q & ~halted_q & ~hazard[2];

`ifdef CONTROL_HALT_LATCH_EN
   logic halted_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         active_q <= active_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      active_d = 1'b1;
      halted_d = halted_q | (decode_en & (opcode == OP_HALT));
   end
`else
   assign halted_q = 1'b0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_q <= 1'b0;
      end else begin
         active_q <= active_d;
      end
   end

   always_comb begin
      active_d = 1'b1;
   end
`endif

   always_comb begin
      byte_access    = 2'b00;
      alu_op         = 3'b000;
      alu_src        = 2'b00;
      write_back     = 2'b00;
      mem_write      = 1'b0;
      mem_read       = 1'b0;
      write_enable_1 = 1'b0;
      write_enable_2 = 1'b0;
      write_data_2   = 1'b0;
      if_flush       = 1'b0;
      pc_src         = 1'b0;
      if (decode_en) begin
         case (opcode)
            OP_RTYPE: begin
               case (funct_code)
                  FN_ADD: begin
                     write_enable_1 = 1'b1;
                  end
                  FN_SUB: begin
                     alu_op         = 3'b001;
                     write_enable_1 = 1'b1;
                  end
                  FN_MULT: begin
                     alu_op         = 3'b010;
                     write_enable_1 = 1'b1;
                     write_enable_2 = 1'b1;
                  end
                  FN_DIV: begin
                     alu_op         = 3'b011;
                     write_enable_1 = 1'b1;
                     write_enable_2 = 1'b1;
                  end
                  FN_MOVE: begin
                     alu_op         = 3'b110;
                     write_enable_1 = 1'b1;
                  end
                  FN_SWAP: begin
                     alu_op         = 3'b111;
                     write_enable_1 = 1'b1;
                     write_enable_2 = 1'b1;
                     write_data_2   = 1'b1;
                  end
                  default: ;
               endcase
            end
            OP_ANDI, OP_ORI: begin
               alu_op         = (opcode == OP_ANDI) ? 3'b100 : 3'b101;
               alu_src        = 2'b10;
               write_enable_1 = 1'b1;
            end
            OP_LB, OP_LW: begin
               byte_access    = (opcode == OP_LB) ? 2'b01 : 2'b10;
               alu_src        = 2'b01;
               mem_read       = 1'b1;
               write_back     = 2'b01;
               write_enable_1 = 1'b1;
            end
            OP_SB, OP_SW: begin
               byte_access = (opcode == OP_SB) ? 2'b01 : 2'b10;
               alu_src     = 2'b01;
               mem_write   = 1'b1;
            end
            OP_BLT, OP_BGT, OP_BEQ: begin
               // opcode[1:0] + 1 lines up with the compare code: 01 less, 10 greater, 11 equal.
               if (hazard[1:0] == (opcode[1:0] + 2'b01)) begin
                  alu_op   = 3'b001;
                  if_flush = 1'b1;
                  pc_src   = 1'b1;
               end
            end
            OP_JMP: begin
               if_flush = 1'b1;
               pc_src   = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

   logic       clk;
   logic       rst_n;
   logic [3:0] opcode;
   logic [3:0] funct_code;
   logic [2:0] hazard;
   logic [1:0] byte_access;
   logic [2:0] alu_op;
   logic [1:0] alu_src;
   logic [1:0] write_back;
   logic       mem_write;
   logic       mem_read;
   logic       write_enable_1;
   logic       write_enable_2;
   logic       write_data_2;
   logic       if_flush;
   logic       pc_src;

   int checks = 0;
   int failures = 0;

   control_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .opcode         (opcode),
      .funct_code     (funct_code),
      .hazard         (hazard),
      .byte_access    (byte_access),
      .alu_op         (alu_op),
      .alu_src        (alu_src),
      .write_back     (write_back),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .write_enable_1 (write_enable_1),
      .write_enable_2 (write_enable_2),
      .write_data_2   (write_data_2),
      .if_flush       (if_flush),
      .pc_src         (pc_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed order: ba, alu_op, alu_src, wb, mw, mr, we1, we2, wd2, flush, pc_src
   function automatic logic [15:0] mk(input logic [1:0] ba, input logic [2:0] aop,
                                      input logic [1:0] asrc, input logic [1:0] wb,
                                      input logic mw, input logic mr, input logic we1,
                                      input logic we2, input logic wd2, input logic fl,
                                      input logic pc);
      return {ba, aop, asrc, wb, mw, mr, we1, we2, wd2, fl, pc};
   endfunction

   localparam logic [15:0] ZERO = 16'h0000;

   task automatic drive(input logic [3:0] op, input logic [3:0] fn, input logic [2:0] hz);
      @(negedge clk);
      opcode = op;
      funct_code = fn;
      hazard = hz;
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] expected);
      logic [15:0] observed;
      observed = {byte_access, alu_op, alu_src, write_back, mem_write, mem_read,
                  write_enable_1, write_enable_2, write_data_2, if_flush, pc_src};
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [15:0] e_add, e_mult, e_swap, e_lb;
      logic [3:0]  undef_ops [4];
      e_add  = mk(2'b00, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      e_mult = mk(2'b00, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      e_swap = mk(2'b00, 3'b111, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      e_lb   = mk(2'b01, 3'b000, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      undef_ops[0] = 4'b0011;
      undef_ops[1] = 4'b0111;
      undef_ops[2] = 4'b1101;
      undef_ops[3] = 4'b1110;

      rst_n = 1'b0;
      opcode = 4'b0000;
      funct_code = 4'b0000;
      hazard = 3'b000;
      repeat (2) @(posedge clk);
      drive(4'b0000, 4'b0000, 3'b000);
      check("reset_zero", ZERO);

      rst_n = 1'b1;
      #1;
      check("pre_active_zero", ZERO);

      drive(4'b0000, 4'b0000, 3'b000);
      check("r_add", e_add);
      drive(4'b0000, 4'b0100, 3'b000);
      check("r_mult", e_mult);
      drive(4'b0000, 4'b0001, 3'b000);
      check("r_sub", mk(2'b00, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(4'b0000, 4'b1000, 3'b000);
      check("r_div", mk(2'b00, 3'b011, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      drive(4'b0000, 4'b1110, 3'b000);
      check("r_move", mk(2'b00, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(4'b0000, 4'b1111, 3'b000);
      check("r_swap", e_swap);
      drive(4'b0000, 4'b0010, 3'b000);
      check("r_bad_funct", ZERO);

      drive(4'b0001, 4'b0000, 3'b000);
      check("andi", mk(2'b00, 3'b100, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(4'b0010, 4'b0000, 3'b000);
      check("ori", mk(2'b00, 3'b101, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

      drive(4'b1000, 4'b0000, 3'b000);
      check("load_byte", e_lb);
      drive(4'b1010, 4'b0000, 3'b000);
      check("load_word", mk(2'b10, 3'b000, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(4'b1001, 4'b0000, 3'b000);
      check("store_byte", mk(2'b01, 3'b000, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(4'b1011, 4'b0000, 3'b000);
      check("store_word", mk(2'b10, 3'b000, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(4'b1011, 4'b0000, 3'b110);
      check("store_stall", ZERO);

      drive(4'b0100, 4'b0000, 3'b001);
      check("blt_taken", mk(2'b00, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      drive(4'b0100, 4'b0000, 3'b010);
      check("blt_not_taken", ZERO);
      drive(4'b0101, 4'b0000, 3'b010);
      check("bgt_taken", mk(2'b00, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      drive(4'b0101, 4'b0000, 3'b001);
      check("bgt_not_taken", ZERO);
      drive(4'b0110, 4'b0000, 3'b011);
      check("beq_taken", mk(2'b00, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      drive(4'b0110, 4'b0000, 3'b111);
      check("beq_stall", ZERO);
      drive(4'b1100, 4'b0000, 3'b000);
      check("jump", mk(2'b00, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      drive(4'b1100, 4'b0000, 3'b100);
      check("jump_stall", ZERO);

      for (int i = 0; i < 4; i++) begin
         drive(undef_ops[i], 4'b0000, 3'b011);
         check($sformatf("undef_%b", undef_ops[i]), ZERO);
      end

      drive(4'b1111, 4'b0000, 3'b100);
      check("halt_stalled", ZERO);
      drive(4'b0000, 4'b0000, 3'b000);
      check("add_after_stalled_halt", e_add);

      drive(4'b1111, 4'b0000, 3'b001);
      check("halt_outputs", ZERO);
      drive(4'b0000, 4'b0000, 3'b000);
`ifdef CONTROL_HALT_LATCH_EN
      check("halted_add", ZERO);
      drive(4'b0000, 4'b0100, 3'b000);
      check("halted_mult", ZERO);
`else
      check("nop_halt_add", e_add);
      drive(4'b0000, 4'b0100, 3'b000);
      check("nop_halt_mult", e_mult);
`endif

      @(negedge clk);
      rst_n = 1'b0;
      #1;
      drive(4'b0000, 4'b0000, 3'b000);
      check("reset_again_zero", ZERO);
      rst_n = 1'b1;
      drive(4'b0000, 4'b0000, 3'b000);
      check("post_reset_add", e_add);
      drive(4'b0000, 4'b1111, 3'b000);
      check("post_reset_swap", e_swap);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
